ifu_fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the decode stage in the multi-cycle NPC core. It owns the architectural PC and issues one word read per instruction on a simple req/gnt/rvalid instruction bus. It registers the returned instruction and presents it to decode with an IFU_valid/IDU_ready handshake. It then waits for the next PC from writeback before starting the next fetch.

---
 rtl/ifu_fetch_stage.sv | 129 ++++++++++++
 tb/tb_ifu_fetch_stage.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: owns the architectural PC, issues one word read per
// instruction on a req/gnt/rvalid bus, registers the returned word and hands it
// to decode with a valid/ready handshake, then waits for the next PC from
// writeback. Exactly one transaction is outstanding at any time.
module ifu_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction bus
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  // toward decode
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        IFU_valid,
  input  logic        IDU_ready,
  // from writeback
  input  logic        npc_valid,
  input  logic [31:0] npc,
  // status
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_NPC  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e      r_state_q, r_state_d;
  logic [31:0] r_pc_q,    r_pc_d;
  logic [31:0] r_inst_q,  r_inst_d;
  logic [31:0] r_cnt_q,   r_cnt_d;
  logic        r_err_q,   r_err_d;

  logic        w_npc_misaligned;

  assign w_npc_misaligned = (npc[1:0] != 2'b00);

  // State and datapath registers; reset abandons any in-flight bus transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= S_REQ;
      r_pc_q    <= RESET_PC;
      r_inst_q  <= 32'h0;
      r_cnt_q   <= 32'h0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_pc_q    <= r_pc_d;
      r_inst_q  <= r_inst_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
    end
  end

  // Next-state logic; inputs outside the state that consumes them are ignored.
  always_comb begin
    r_state_d = r_state_q;
    r_pc_d    = r_pc_q;
    r_inst_d  = r_inst_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    case (r_state_q)
      S_REQ: begin
        if (mem_gnt) begin
          r_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (mem_err) begin
            // Faulting fetch leaves the previous instruction in place.
            r_err_d   = 1'b1;
            r_state_d = S_ERR;
          end else begin
            r_inst_d  = mem_rdata;
            r_state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (IDU_ready) begin
          r_cnt_d   = r_cnt_q + 32'd1;
          r_state_d = S_NPC;
        end
      end
      S_NPC: begin
        if (npc_valid) begin
          r_pc_d = npc;
          if (w_npc_misaligned) begin
            r_err_d   = 1'b1;
            r_state_d = S_ERR;
          end else begin
            r_state_d = S_REQ;
          end
        end
      end
      S_ERR: begin
        r_err_d = 1'b1;
      end
      default: begin
        // Unreachable encodings park in the fault state.
        r_err_d   = 1'b1;
        r_state_d = S_ERR;
      end
    endcase
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    mem_req   = (r_state_q == S_REQ);
    mem_addr  = r_pc_q;
    IFU_valid = (r_state_q == S_OUT);
    inst      = r_inst_q;
    pc        = r_pc_q;
    fetch_err = r_err_q;
    fetch_cnt = r_cnt_q;
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Self-checking bench for ifu_fetch_stage. Inputs are driven and outputs are
// sampled on the falling edge; the model tracks pc / inst / count / error at
// the transaction level from what the bench itself drove.
module tb_ifu_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        IFU_valid;
  logic        IDU_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level model
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;

  ifu_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .inst       (inst),
    .pc         (pc),
    .IFU_valid  (IFU_valid),
    .IDU_ready  (IDU_ready),
    .npc_valid  (npc_valid),
    .npc        (npc),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_err    = 1'b0;
    IDU_ready  = 1'b0;
    npc_valid  = 1'b0;
    npc        = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_pc   = RST_PC;
    m_inst = 32'h0;
    m_cnt  = 32'h0;
  endtask

  // Stimulus only: one clean fetch starting in the request phase, ending with
  // the next PC presented (aligned), so the stage is requesting again.
  task automatic drive_fetch(input logic [31:0] data, input logic [31:0] next_pc);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    IDU_ready  = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
    IDU_ready = 1'b0;
    npc_valid = 1'b1;
    npc       = next_pc;
    tick();
    npc_valid = 1'b0;
    m_inst = data;
    m_cnt  = m_cnt + 32'd1;
    m_pc   = next_pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    n_tests++;
    if ({pc, inst, fetch_cnt, fetch_err, IFU_valid} !== {RST_PC, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got pc=%h inst=%h cnt=%0d err=%b vld=%b want pc=%h 0 0 0 0",
               pc, inst, fetch_cnt, fetch_err, IFU_valid, RST_PC);
    end
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_pc   = RST_PC;
    m_inst = 32'h0;
    m_cnt  = 32'h0;
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h want 1 %h", mem_req, mem_addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    n_tests++;
    if ({mem_req, mem_addr, IFU_valid} !== {1'b1, RST_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_req: got req=%b addr=%h vld=%b want 1 %h 0", mem_req, mem_addr,
               IFU_valid, RST_PC);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0513;
    IDU_ready  = 1'b1;
    n_tests++;
    if ({mem_req, IFU_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_wait: got req=%b vld=%b want 0 0", mem_req, IFU_valid);
    end
    tick();
    mem_rvalid = 1'b0;
    n_tests++;
    if ({IFU_valid, inst, pc} !== {1'b1, 32'h0000_0513, RST_PC}) begin
      n_fail++;
      $display("FAIL basic_out: got vld=%b inst=%h pc=%h want 1 00000513 %h", IFU_valid, inst,
               pc, RST_PC);
    end
    tick();
    IDU_ready = 1'b0;
    n_tests++;
    if ({fetch_cnt, IFU_valid, mem_req} !== {32'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_fire: got cnt=%0d vld=%b req=%b want 1 0 0", fetch_cnt, IFU_valid,
               mem_req);
    end
    npc_valid = 1'b1;
    npc       = 32'h8000_0100;
    tick();
    npc_valid = 1'b0;
    n_tests++;
    if ({mem_req, mem_addr, pc} !== {1'b1, 32'h8000_0100, 32'h8000_0100}) begin
      n_fail++;
      $display("FAIL basic_npc: got req=%b addr=%h pc=%h want 1 80000100 80000100", mem_req,
               mem_addr, pc);
    end
    m_cnt  = 32'd1;
    m_pc   = 32'h8000_0100;
    m_inst = 32'h0000_0513;
  endtask

  // Continues from the request phase left by test_basic.
  task automatic test_backpressure();
    logic [31:0] data;
    data    = $urandom();
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      // stray next-PC pulses while decode stalls must be ignored
      npc_valid = 1'b1;
      npc       = 32'h8000_0200 + 32'(c * 4);
      n_tests++;
      if ({IFU_valid, inst, pc, fetch_cnt} !== {1'b1, data, m_pc, m_cnt}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b inst=%h pc=%h cnt=%0d want 1 %h %h %0d", c,
                 IFU_valid, inst, pc, fetch_cnt, data, m_pc, m_cnt);
      end
      tick();
    end
    npc_valid = 1'b0;
    IDU_ready = 1'b1;
    n_tests++;
    if ({IFU_valid, inst, pc} !== {1'b1, data, m_pc}) begin
      n_fail++;
      $display("FAIL bp_fire_cycle: got vld=%b inst=%h pc=%h want 1 %h %h", IFU_valid, inst, pc,
               data, m_pc);
    end
    tick();
    m_cnt = m_cnt + 32'd1;
    tick();
    IDU_ready = 1'b0;
    n_tests++;
    if ({fetch_cnt, IFU_valid, mem_req, pc} !== {m_cnt, 1'b0, 1'b0, m_pc}) begin
      n_fail++;
      $display("FAIL bp_single_incr: got cnt=%0d vld=%b req=%b pc=%h want %0d 0 0 %h", fetch_cnt,
               IFU_valid, mem_req, pc, m_cnt, m_pc);
    end
    npc_valid = 1'b1;
    npc       = m_pc + 32'd4;
    tick();
    npc_valid = 1'b0;
    m_pc      = m_pc + 32'd4;
    m_inst    = data;
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, m_pc}) begin
      n_fail++;
      $display("FAIL bp_next_req: got req=%b addr=%h want 1 %h", mem_req, mem_addr, m_pc);
    end
  endtask

  task automatic test_slow_mem();
    logic [31:0] data;
    data = $urandom();
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if ({mem_req, mem_addr} !== {1'b1, m_pc}) begin
        n_fail++;
        $display("FAIL slow_req[%0d]: got req=%b addr=%h want 1 %h", c, mem_req, mem_addr, m_pc);
      end
      mem_rvalid = (c == 1);
      mem_rdata  = 32'hDEAD_BEEF;
      mem_gnt    = (c == 3);
      tick();
    end
    mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if ({mem_req, IFU_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL slow_wait[%0d]: got req=%b vld=%b want 0 0", c, mem_req, IFU_valid);
      end
      mem_rvalid = (c == 3);
      mem_rdata  = (c == 3) ? data : 32'hBAD0_0000;
      tick();
    end
    mem_rvalid = 1'b0;
    n_tests++;
    if ({IFU_valid, inst, pc} !== {1'b1, data, m_pc}) begin
      n_fail++;
      $display("FAIL slow_data: got vld=%b inst=%h pc=%h want 1 %h %h", IFU_valid, inst, pc,
               data, m_pc);
    end
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    npc_valid = 1'b1;
    npc       = m_pc + 32'd8;
    tick();
    npc_valid = 1'b0;
    m_cnt  = m_cnt + 32'd1;
    m_pc   = m_pc + 32'd8;
    m_inst = data;
    n_tests++;
    if ({fetch_cnt, mem_req, mem_addr} !== {m_cnt, 1'b1, m_pc}) begin
      n_fail++;
      $display("FAIL slow_after: got cnt=%0d req=%b addr=%h want %0d 1 %h", fetch_cnt, mem_req,
               mem_addr, m_cnt, m_pc);
    end
  endtask

  task automatic test_random();
    int unsigned d;
    logic [31:0] data;
    logic [31:0] nxt;
    apply_reset();
    for (int it = 0; it < 25; it++) begin
      d = $urandom_range(0, 3);
      for (int c = 0; c <= int'(d); c++) begin
        n_tests++;
        if ({mem_req, mem_addr, IFU_valid, fetch_err} !== {1'b1, m_pc, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_req[%0d]: got req=%b addr=%h vld=%b err=%b want 1 %h 0 0", it,
                   mem_req, mem_addr, IFU_valid, fetch_err, m_pc);
        end
        mem_gnt    = (c == int'(d));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_err    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom();
        npc_valid  = 1'($urandom_range(0, 1));
        npc        = $urandom();
        IDU_ready  = 1'($urandom_range(0, 1));
        tick();
      end
      data = $urandom();
      d    = $urandom_range(0, 3);
      for (int c = 0; c <= int'(d); c++) begin
        n_tests++;
        if ({mem_req, IFU_valid, fetch_cnt} !== {1'b0, 1'b0, m_cnt}) begin
          n_fail++;
          $display("FAIL rnd_wait[%0d]: got req=%b vld=%b cnt=%0d want 0 0 %0d", it, mem_req,
                   IFU_valid, fetch_cnt, m_cnt);
        end
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = (c == int'(d));
        mem_err    = (c == int'(d)) ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata  = (c == int'(d)) ? data : $urandom();
        npc_valid  = 1'($urandom_range(0, 1));
        npc        = $urandom();
        IDU_ready  = 1'($urandom_range(0, 1));
        tick();
      end
      m_inst = data;
      d = $urandom_range(0, 3);
      for (int c = 0; c <= int'(d); c++) begin
        n_tests++;
        if ({IFU_valid, inst, pc, mem_req} !== {1'b1, m_inst, m_pc, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_out[%0d]: got vld=%b inst=%h pc=%h req=%b want 1 %h %h 0", it,
                   IFU_valid, inst, pc, mem_req, m_inst, m_pc);
        end
        IDU_ready  = (c == int'(d));
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_err    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom();
        npc_valid  = 1'($urandom_range(0, 1));
        npc        = $urandom();
        tick();
      end
      m_cnt = m_cnt + 32'd1;
      nxt = $urandom();
      nxt[1:0] = 2'b00;
      d = $urandom_range(0, 3);
      for (int c = 0; c <= int'(d); c++) begin
        n_tests++;
        if ({IFU_valid, mem_req, fetch_cnt, inst} !== {1'b0, 1'b0, m_cnt, m_inst}) begin
          n_fail++;
          $display("FAIL rnd_npc[%0d]: got vld=%b req=%b cnt=%0d inst=%h want 0 0 %0d %h", it,
                   IFU_valid, mem_req, fetch_cnt, inst, m_cnt, m_inst);
        end
        npc_valid  = (c == int'(d));
        npc        = (c == int'(d)) ? nxt : $urandom();
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_err    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom();
        IDU_ready  = 1'($urandom_range(0, 1));
        tick();
      end
      m_pc = nxt;
    end
    idle_inputs();
  endtask

  task automatic test_npc_misaligned();
    apply_reset();
    drive_fetch(32'h0000_0093, 32'h8000_0040);
    drive_fetch(32'h0000_0113, 32'h8000_0044);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0193;
    IDU_ready  = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
    IDU_ready = 1'b0;
    npc_valid = 1'b1;
    npc       = 32'h8000_0102;
    tick();
    m_cnt = m_cnt + 32'd1;
    n_tests++;
    if ({fetch_err, mem_req, IFU_valid, pc, fetch_cnt} !==
        {1'b1, 1'b0, 1'b0, 32'h8000_0102, m_cnt}) begin
      n_fail++;
      $display("FAIL npc_err: got err=%b req=%b vld=%b pc=%h cnt=%0d want 1 0 0 80000102 %0d",
               fetch_err, mem_req, IFU_valid, pc, fetch_cnt, m_cnt);
    end
    npc       = 32'h8000_0200;
    mem_gnt   = 1'b1;
    mem_rvalid = 1'b1;
    IDU_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if ({fetch_err, mem_req, IFU_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL npc_err_sticky[%0d]: got err=%b req=%b vld=%b want 1 0 0", c, fetch_err,
                 mem_req, IFU_valid);
      end
    end
    apply_reset();
    n_tests++;
    if ({fetch_err, mem_req, mem_addr, fetch_cnt} !== {1'b0, 1'b1, RST_PC, 32'h0}) begin
      n_fail++;
      $display("FAIL npc_err_recover: got err=%b req=%b addr=%h cnt=%0d want 0 1 %h 0",
               fetch_err, mem_req, mem_addr, fetch_cnt, RST_PC);
    end
  endtask

  task automatic test_bus_err();
    apply_reset();
    drive_fetch(32'h1234_5678, 32'h8000_0010);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_err    = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    IDU_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      n_tests++;
      if ({fetch_err, IFU_valid, mem_req, inst, fetch_cnt} !==
          {1'b1, 1'b0, 1'b0, m_inst, m_cnt}) begin
        n_fail++;
        $display("FAIL bus_err[%0d]: got err=%b vld=%b req=%b inst=%h cnt=%0d want 1 0 0 %h %0d",
                 c, fetch_err, IFU_valid, mem_req, inst, fetch_cnt, m_inst, m_cnt);
      end
    end
    apply_reset();
    n_tests++;
    if ({fetch_err, mem_req, inst} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL bus_err_recover: got err=%b req=%b inst=%h want 0 1 0", fetch_err, mem_req,
               inst);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] data;
    apply_reset();
    drive_fetch(32'hCAFE_0001, 32'h8000_0080);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    // mid-cycle, away from any clock edge
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({pc, inst, fetch_cnt, fetch_err, IFU_valid, mem_req} !==
        {RST_PC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_rst: got pc=%h inst=%h cnt=%0d err=%b vld=%b req=%b want %h 0 0 0 0 1",
               pc, inst, fetch_cnt, fetch_err, IFU_valid, mem_req, RST_PC);
    end
    @(negedge clk);
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_0002;
    m_pc   = RST_PC;
    m_inst = 32'h0;
    m_cnt  = 32'h0;
    tick();
    mem_rvalid = 1'b0;
    n_tests++;
    if ({mem_req, mem_addr, IFU_valid, inst} !== {1'b1, RST_PC, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_late_rvalid: got req=%b addr=%h vld=%b inst=%h want 1 %h 0 0",
               mem_req, mem_addr, IFU_valid, inst, RST_PC);
    end
    data    = $urandom();
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    n_tests++;
    if ({IFU_valid, inst, pc} !== {1'b1, data, RST_PC}) begin
      n_fail++;
      $display("FAIL async_restart: got vld=%b inst=%h pc=%h want 1 %h %h", IFU_valid, inst, pc,
               data, RST_PC);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst    = 1'b1;
    m_pc   = RST_PC;
    m_inst = 32'h0;
    m_cnt  = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_slow_mem();
    test_random();
    test_npc_misaligned();
    test_bus_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
